// File: rtl/lcd_tcon_pkg.sv
// Shared encodings for the parametrised LCD timing controller: display modes,
// colour-bar palette and SDRAM word unpack positions.
package lcd_tcon_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_THRESH = 2'd1,
        MODE_BARS   = 2'd2,
        MODE_LUMA   = 2'd3
    } mode_e;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    // Word 1 carries G[7:3] and B, word 2 carries G[2:0] and R.
    localparam int D1_G_HI = 14;
    localparam int D1_G_LO = 10;
    localparam int D1_B_HI = 9;
    localparam int D1_B_LO = 2;
    localparam int D2_G_HI = 14;
    localparam int D2_G_LO = 12;
    localparam int D2_R_HI = 9;
    localparam int D2_R_LO = 2;

    // {R,G,B} per bar, entry 0 is the leftmost (white) bar.
    localparam logic [7:0][23:0] BAR_RGB = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

endpackage

// File: rtl/lcd_timing_gen.sv
// Raster counters, active-window decode and the early frame-buffer read strobe.
module lcd_timing_gen
    import lcd_tcon_pkg::*;
#(
    parameter int H_LINE  = 1056,
    parameter int V_LINE  = 525,
    parameter int H_BLANK = 216,
    parameter int H_FRONT = 40,
    parameter int V_BACK  = 35,
    parameter int V_FRONT = 10,
    parameter int RD_LEAD = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic [X_W-1:0] x_cnt,
    output logic [Y_W-1:0] y_cnt,
    output logic           display_area,
    output logic           read_en
);

    localparam logic [X_W-1:0] X_LAST  = X_W'(H_LINE - 1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_LINE - 1);
    localparam logic [X_W-1:0] X_ACT_S = X_W'(H_BLANK);
    localparam logic [X_W-1:0] X_ACT_E = X_W'(H_LINE - H_FRONT);
    localparam logic [X_W-1:0] X_RD_S  = X_W'(H_BLANK - RD_LEAD);
    localparam logic [X_W-1:0] X_RD_E  = X_W'(H_LINE - H_FRONT - RD_LEAD);
    localparam logic [Y_W-1:0] Y_ACT_S = Y_W'(V_BACK);
    localparam logic [Y_W-1:0] Y_ACT_E = Y_W'(V_LINE - V_FRONT);

    logic v_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (x_cnt == X_LAST) begin
            x_cnt <= '0;
            y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + Y_W'(1);
        end else begin
            x_cnt <= x_cnt + X_W'(1);
        end
    end

    // The read window is the display window slid left by RD_LEAD, so each line
    // still gets exactly one strobe per active pixel.
    always_comb begin
        v_win        = (y_cnt >= Y_ACT_S) && (y_cnt < Y_ACT_E);
        display_area = v_win && (x_cnt >= X_ACT_S) && (x_cnt < X_ACT_E);
        read_en      = v_win && (x_cnt >= X_RD_S) && (x_cnt < X_RD_E);
    end

endmodule

// File: rtl/lcd_tcon_param.sv
// Parametrised LCD timing controller: sync/DE generation, pixel unpack,
// per-frame display mode and overlay coordinates.
module lcd_tcon_param
    import lcd_tcon_pkg::*;
#(
    parameter int H_LINE      = 1056,
    parameter int V_LINE      = 525,
    parameter int H_BLANK     = 216,
    parameter int H_FRONT     = 40,
    parameter int V_BACK      = 35,
    parameter int V_FRONT     = 10,
    parameter int VSYNC_LINES = 1,
    parameter int RD_LEAD     = 1,
    parameter int PIX_W       = 8
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic [15:0]      iREAD_DATA1,
    input  logic [15:0]      iREAD_DATA2,
    input  logic [1:0]       iMODE,
    input  logic [7:0]       iTHRESH,
    output logic             oREAD_SDRAM_EN,
    output logic             oHD,
    output logic             oVD,
    output logic             oDEN,
    output logic [PIX_W-1:0] oLCD_R,
    output logic [PIX_W-1:0] oLCD_G,
    output logic [PIX_W-1:0] oLCD_B,
    output logic [10:0]      oX,
    output logic [9:0]       oY,
    output logic             oFRAME_START
);

    localparam int H_ACT = H_LINE - H_BLANK - H_FRONT;
    localparam int BAR_W = H_ACT / 8;
    localparam logic [X_W-1:0] X_ACT_S    = X_W'(H_BLANK);
    localparam logic [Y_W-1:0] Y_ACT_S    = Y_W'(V_BACK);
    localparam logic [Y_W-1:0] VSYNC_END  = Y_W'(VSYNC_LINES);
    localparam logic [X_W-1:0] BAR_LAST   = X_W'(BAR_W - 1);

    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic           display_area;
    logic           frame_origin;
    mode_e          mode_q;
    logic [7:0]     thresh_q;
    logic [2:0]     bar_idx;
    logic [X_W-1:0] bar_pos;
    logic [7:0]     r8, g8, b8, y8;
    logic [23:0]    pix_p0;
    logic           unused_data;

    function automatic logic [7:0] luma_sat(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
        logic [10:0] sum;
        sum = {2'b00, r, 1'b0} + (11'(g) * 11'd5) + 11'(b);
        sum = sum >> 3;
        return (sum > 11'd255) ? 8'hFF : sum[7:0];
    endfunction

    lcd_timing_gen #(
        .H_LINE (H_LINE),
        .V_LINE (V_LINE),
        .H_BLANK(H_BLANK),
        .H_FRONT(H_FRONT),
        .V_BACK (V_BACK),
        .V_FRONT(V_FRONT),
        .RD_LEAD(RD_LEAD)
    ) u_timing (
        .clk         (iCLK),
        .rst_n       (iRST_n),
        .x_cnt       (x_cnt),
        .y_cnt       (y_cnt),
        .display_area(display_area),
        .read_en     (oREAD_SDRAM_EN)
    );

    assign frame_origin = (x_cnt == '0) && (y_cnt == '0);
    assign unused_data  = ^{iREAD_DATA1[15], iREAD_DATA1[1:0],
                            iREAD_DATA2[15], iREAD_DATA2[11:10], iREAD_DATA2[1:0]};

    // Mode and threshold only change at the raster origin, never mid-frame.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            mode_q   <= MODE_PASS;
            thresh_q <= 8'h00;
        end else if (frame_origin) begin
            mode_q   <= mode_e'(iMODE);
            thresh_q <= iTHRESH;
        end
    end

    // Bar position tracked by counting, restarting at every line's first pixel;
    // the last bar absorbs any remainder of H_ACT/8.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            bar_idx <= '0;
            bar_pos <= '0;
        end else if (!display_area) begin
            bar_idx <= '0;
            bar_pos <= '0;
        end else if (bar_pos == BAR_LAST && bar_idx != 3'd7) begin
            bar_idx <= bar_idx + 3'd1;
            bar_pos <= '0;
        end else begin
            bar_pos <= bar_pos + X_W'(1);
        end
    end

    // Stage p0: unpack and mode select on the counter state.
    always_comb begin
        r8     = iREAD_DATA2[D2_R_HI:D2_R_LO];
        g8     = {iREAD_DATA1[D1_G_HI:D1_G_LO], iREAD_DATA2[D2_G_HI:D2_G_LO]};
        b8     = iREAD_DATA1[D1_B_HI:D1_B_LO];
        y8     = luma_sat(r8, g8, b8);
        pix_p0 = 24'h000000;
        if (display_area) begin
            case (mode_q)
                MODE_PASS:   pix_p0 = {r8, g8, b8};
                MODE_THRESH: pix_p0 = (r8 > thresh_q) ? 24'hFFFFFF : 24'h000000;
                MODE_BARS:   pix_p0 = BAR_RGB[bar_idx];
                MODE_LUMA:   pix_p0 = {3{y8}};
                default:     pix_p0 = 24'h000000;
            endcase
        end
    end

    // Stage p1: every LCD-side output is registered one clock after the counters.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oHD          <= 1'b0;
            oVD          <= 1'b0;
            oDEN         <= 1'b0;
            oLCD_R       <= '0;
            oLCD_G       <= '0;
            oLCD_B       <= '0;
            oX           <= '0;
            oY           <= '0;
            oFRAME_START <= 1'b0;
        end else begin
            oHD          <= (x_cnt != '0);
            oVD          <= (y_cnt >= VSYNC_END);
            oDEN         <= display_area;
            oLCD_R       <= pix_p0[23 -: PIX_W];
            oLCD_G       <= pix_p0[15 -: PIX_W];
            oLCD_B       <= pix_p0[7 -: PIX_W];
            oX           <= display_area ? (x_cnt - X_ACT_S) : '0;
            oY           <= display_area ? (y_cnt - Y_ACT_S) : '0;
            oFRAME_START <= display_area && (x_cnt == X_ACT_S) && (y_cnt == Y_ACT_S);
        end
    end

endmodule
